// File: rtl/signed_add_arbiter.sv
// signed_add_arbiter
//   Round-robin arbiter sharing one signed two's-complement adder among
//   N_REQ requesters, with a single registered result slot (EMPTY/FULL)
//   under valid/ready backpressure and a saturating overflow event counter.
//
//   Optional feature macro: SIGNED_ADD_ARB_SATURATE_EN
//     defined   -> an overflowing sum clamps to the most positive/negative value
//     undefined -> the sum wraps to its low W bits
module signed_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [W-1:0]             res_sum,
    output logic                     res_overflow,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int              ID_W    = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
`ifdef SIGNED_ADD_ARB_SATURATE_EN
    localparam logic [W-1:0]    SUM_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]    SUM_MIN = {1'b1, {(W-1){1'b0}}};
`endif

    // Output slot occupancy; res_valid is simply "slot is FULL".
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic [W-1:0]      a_sel, b_sel;
    logic [W-1:0]      sum_wrap, sum_out;
    logic              ovf;
    logic              can_accept;
    logic              accept;

    // Round-robin search: first valid requester at or after ptr_q, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        found  = 1'b0;
        winner = '0;
        idx    = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == LAST_ID) ? '0 : idx + ID_W'(1);
        end
    end

    // Route the winner's operands to the shared adder.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    // Shared signed adder: overflow only when like-signed operands yield an
    // opposite-signed result.
    always_comb begin
        sum_wrap = a_sel + b_sel;
        ovf      = (a_sel[W-1] == b_sel[W-1]) && (sum_wrap[W-1] != a_sel[W-1]);
`ifdef SIGNED_ADD_ARB_SATURATE_EN
        sum_out  = ovf ? (a_sel[W-1] ? SUM_MIN : SUM_MAX) : sum_wrap;
`else
        sum_out  = sum_wrap;
`endif
    end

    // Handshake: the slot can take a new result when empty or being drained.
    always_comb begin
        can_accept = (state_q == EMPTY) || res_ready;
        accept     = found && can_accept && !rst;
        req_ready  = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state: load on accept, drain on consume, otherwise hold.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FULL;
            id_d    = winner;
            sum_d   = sum_out;
            ovf_d   = ovf;
            ptr_d   = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
            if (ovf && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the result data fields are reset as well, not only the
            // valid bit, because their reset values are visible on the ports.
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_valid    = (state_q == FULL);
    assign res_id       = id_q;
    assign res_sum      = sum_q;
    assign res_overflow = ovf_q;
    assign ovf_count    = cnt_q;

endmodule
